// File: rtl/exp_accumulate_block_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exp_accumulate_block_pkg                                        |
// | Brief    : Shared state encoding, Q16.16 constant and sizing helper for    |
// |            the softmax exp accumulate/replay block.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package exp_accumulate_block_pkg;

  // Frame-level control states; encodings are fixed so debug probes stay stable.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SUM_OUT = 2'd1,
    REPLAY  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // 1.0 in unsigned Q16.16.
  localparam logic [31:0] c_q16_one = 32'h0001_0000;

  // Address width for a buffer of the given depth (a depth of 1 still needs one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exp_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exp_frame_buffer                                                |
// | Brief    : One-frame register array holding exp values; synchronous write, |
// |            registered read with read enable so the output can be held.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module exp_frame_buffer #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int addr_size      = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 i_we,
  input  logic [addr_size-1:0] i_waddr,
  input  logic [data_size-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [addr_size-1:0] i_raddr,
  output logic [data_size-1:0] o_rdata
);

  logic [data_size-1:0] r_mem [number_of_data];
  logic [data_size-1:0] r_rdata;

  // Storage needs no reset: contents are only read after being written this frame.
  always_ff @(posedge clock_i) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register is reset so the replay data output is clean after an abort.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)   r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/exp_accumulate_block.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exp_accumulate_block                                            |
// | Brief    : Captures a frame of exp values, emits their sum once, then      |
// |            replays the values in arrival order over valid/ready.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module exp_accumulate_block
  import exp_accumulate_block_pkg::*;
#(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int sum_size       = 36
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [data_size-1:0] exp_data_i,
  input  logic                 exp_data_valid_i,
  input  logic                 exp_done_i,
  input  logic                 clear_i,
  output logic [sum_size-1:0]  sum_o,
  output logic                 sum_valid_o,
  output logic [data_size-1:0] replay_data_o,
  output logic                 replay_valid_o,
  input  logic                 replay_ready_i,
  output logic                 replay_last_o,
  output logic                 accum_done_o,
  output logic                 overflow_o
);

  localparam int CNT_W  = $clog2(number_of_data + 1);
  localparam int ADDR_W = addr_width(number_of_data);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(number_of_data);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_done_d;
  logic [CNT_W-1:0]     r_wr_cnt;
  logic [CNT_W-1:0]     r_rd_cnt;
  logic [sum_size-1:0]  r_sum;
  logic [sum_size-1:0]  r_sum_out;
  logic                 r_sum_valid;
  logic                 r_replay_valid;
  logic                 r_accum_done;
  logic                 r_overflow;

  logic                 w_done_edge;
  logic                 w_collect;
  logic                 w_capture;
  logic                 w_drop;
  logic                 w_xfer;
  logic                 w_is_last;
  logic                 w_last_xfer;
  logic                 w_clear;
  logic                 w_re;
  logic [CNT_W-1:0]     w_raddr_cnt;
  logic [sum_size-1:0]  w_exp_ext;

  // Only the rising edge of done ends a frame, so a level held high cannot retrigger.
  assign w_done_edge = exp_done_i & ~r_done_d;
  assign w_collect   = (r_state == COLLECT);
  assign w_capture   = w_collect & exp_data_valid_i & (r_wr_cnt < c_depth);
  assign w_drop      = w_collect & exp_data_valid_i & (r_wr_cnt == c_depth);
  assign w_xfer      = r_replay_valid & replay_ready_i;
  assign w_is_last   = (r_rd_cnt == (r_wr_cnt - CNT_W'(1)));
  assign w_last_xfer = w_xfer & w_is_last;
  assign w_clear     = (r_state == DONE) & clear_i;
  assign w_exp_ext   = {{(sum_size - data_size){1'b0}}, exp_data_i};

  // Look one entry ahead on a transfer so the next beat is ready right after it;
  // reading stops on the final transfer so the address never passes the frame.
  assign w_raddr_cnt = w_xfer ? (r_rd_cnt + CNT_W'(1)) : r_rd_cnt;
  assign w_re        = (r_state == SUM_OUT) | ((r_state == REPLAY) & ~w_last_xfer);

  exp_frame_buffer #(
    .data_size      (data_size),
    .number_of_data (number_of_data),
    .addr_size      (ADDR_W)
  ) u_buffer (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .i_we    (w_capture),
    .i_waddr (r_wr_cnt[ADDR_W-1:0]),
    .i_wdata (exp_data_i),
    .i_re    (w_re),
    .i_raddr (w_raddr_cnt[ADDR_W-1:0]),
    .o_rdata (replay_data_o)
  );

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_state <= COLLECT;
    else         r_state <= w_state_next;
  end

  // Next-state logic; SUM_OUT always lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (w_done_edge) w_state_next = SUM_OUT;
      SUM_OUT: w_state_next = (r_wr_cnt != '0) ? REPLAY : DONE;
      REPLAY:  if (w_last_xfer) w_state_next = DONE;
      DONE:    if (clear_i) w_state_next = COLLECT;
      default: w_state_next = COLLECT;
    endcase
  end

  // Counters, accumulator and registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_done_d       <= 1'b0;
      r_wr_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_sum          <= '0;
      r_sum_out      <= '0;
      r_sum_valid    <= 1'b0;
      r_replay_valid <= 1'b0;
      r_accum_done   <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_done_d    <= exp_done_i;
      r_sum_valid <= (r_state == SUM_OUT);
      if (r_state == SUM_OUT) r_sum_out <= r_sum;
      if (w_capture) begin
        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        r_sum    <= r_sum + w_exp_ext;
      end
      if (w_drop) r_overflow <= 1'b1;
      if (w_last_xfer)            r_replay_valid <= 1'b0;
      else if (r_state == REPLAY) r_replay_valid <= 1'b1;
      if (w_xfer) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (((r_state == SUM_OUT) && (r_wr_cnt == '0)) || w_last_xfer) r_accum_done <= 1'b1;
      if (w_clear) begin
        r_wr_cnt     <= '0;
        r_rd_cnt     <= '0;
        r_sum        <= '0;
        r_overflow   <= 1'b0;
        r_accum_done <= 1'b0;
      end
    end
  end

  assign sum_o          = r_sum_out;
  assign sum_valid_o    = r_sum_valid;
  assign replay_valid_o = r_replay_valid;
  assign replay_last_o  = r_replay_valid & w_is_last;
  assign accum_done_o   = r_accum_done;
  assign overflow_o     = r_overflow;

endmodule
`default_nettype wire
